// File: rtl/snake_body_engine.sv
// snake_body_engine
// Holds the ordered segment list of one snake on a GRID_W x GRID_H grid.
// It advances one cell per accepted step and queues growth. It rejects a
// direction that reverses the snake, and handles wrap-or-wall edges. A fatal
// move latches the DEAD state until rst or sync.
// Ports:
//   clk, rst (async, active-high)  clock / reset
//   sync                           synchronous restart to the reset state
//   step, dir[1:0]                 advance request and requested direction
//   wrap_en                        1 = wrap at edges, 0 = edges kill
//   grow                           queue one segment of growth
//   body[MAX_LENGTH][SEG_W]        segments {x,y}, index 0 = head, unused = 0
//   head, next_head                current head / combinational target cell
//   length, alive, dead_wall, dead_self, full   status for the renderer
module snake_body_engine #(
    parameter int MAX_LENGTH = 50,
    parameter int X_BITS     = 4,
    parameter int Y_BITS     = 4,
    parameter int GRID_W     = 16,
    parameter int GRID_H     = 12,
    parameter int START_X    = 4,
    parameter int START_Y    = 5,
    parameter int START_LEN  = 3,
    localparam int SEG_W     = X_BITS + Y_BITS,
    localparam int LEN_W     = $clog2(MAX_LENGTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               sync,
    input  logic                               step,
    input  logic [1:0]                         dir,
    input  logic                               wrap_en,
    input  logic                               grow,
    output logic [MAX_LENGTH-1:0][SEG_W-1:0]   body,
    output logic [SEG_W-1:0]                   head,
    output logic [SEG_W-1:0]                   next_head,
    output logic [LEN_W-1:0]                   length,
    output logic                               alive,
    output logic                               dead_wall,
    output logic                               dead_self,
    output logic                               full
);
    typedef enum logic {RUN, DEAD} state_t;
    typedef logic [MAX_LENGTH-1:0][SEG_W-1:0] body_t;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;

    function automatic body_t start_body();
        body_t b = '0;
        for (int i = 0; i < START_LEN; i++)
            b[i] = {X_BITS'(START_X - i), Y_BITS'(START_Y)};
        return b;
    endfunction

    state_t            state, state_nxt;
    body_t             body_nxt;
    logic [LEN_W-1:0]  len_nxt, new_len;
    logic [1:0]        heading, heading_nxt, eff_dir;
    logic [3:0]        pending, pending_nxt, pending_step;
    logic              dead_wall_nxt, dead_self_nxt;
    logic [X_BITS-1:0] hx, nx;
    logic [Y_BITS-1:0] hy, ny;
    logic              edge_hit, wall_hit, grow_now, not_full;
    logic [4:0]        psum;
    logic [MAX_LENGTH-1:0] hit;

    assign hx = body[0][SEG_W-1:Y_BITS];
    assign hy = body[0][Y_BITS-1:0];
    assign not_full = length < LEN_W'(MAX_LENGTH);

    // Target cell. Reversal is only meaningful once there is a neck to run into.
    always_comb begin
        eff_dir  = ((length >= LEN_W'(2)) && (dir == (heading ^ 2'b01))) ? heading : dir;
        nx       = hx;
        ny       = hy;
        edge_hit = 1'b0;
        case (eff_dir)
            DIR_RIGHT: if (hx == X_BITS'(GRID_W - 1)) begin nx = '0; edge_hit = 1'b1; end
                       else nx = hx + 1'b1;
            DIR_LEFT:  if (hx == '0) begin nx = X_BITS'(GRID_W - 1); edge_hit = 1'b1; end
                       else nx = hx - 1'b1;
            DIR_UP:    if (hy == '0) begin ny = Y_BITS'(GRID_H - 1); edge_hit = 1'b1; end
                       else ny = hy - 1'b1;
            default:   if (hy == Y_BITS'(GRID_H - 1)) begin ny = '0; edge_hit = 1'b1; end
                       else ny = hy + 1'b1;
        endcase
        next_head = {nx, ny};
        wall_hit  = edge_hit & ~wrap_en;
        grow_now  = ((pending != 4'd0) || grow) && not_full;
        new_len   = length + LEN_W'(grow_now);
        // A coincident grow is counted and consumed in the same step.
        psum         = {1'b0, pending} + 5'(grow) - 5'(grow_now);
        pending_step = (psum > 5'd15) ? 4'd15 : psum[3:0];
    end

    // Per-segment collision: only segments that survive the shift can be hit,
    // so the vacating tail is excluded unless the snake is growing.
    for (genvar j = 0; j < MAX_LENGTH; j++) begin : g_hit
        assign hit[j] = (body[j] == next_head) && ((LEN_W+1)'(j + 2) <= {1'b0, new_len});
    end

    always_comb begin
        state_nxt     = state;
        body_nxt      = body;
        len_nxt       = length;
        heading_nxt   = heading;
        pending_nxt   = pending;
        dead_wall_nxt = dead_wall;
        dead_self_nxt = dead_self;
        if (sync) begin
            state_nxt     = RUN;
            body_nxt      = start_body();
            len_nxt       = LEN_W'(START_LEN);
            heading_nxt   = DIR_RIGHT;
            pending_nxt   = '0;
            dead_wall_nxt = 1'b0;
            dead_self_nxt = 1'b0;
        end else if (state == RUN) begin
            if (step) begin
                heading_nxt = eff_dir;
                if (wall_hit) begin
                    state_nxt     = DEAD;
                    dead_wall_nxt = 1'b1;
                end else if (|hit) begin
                    state_nxt     = DEAD;
                    dead_self_nxt = 1'b1;
                end else begin
                    body_nxt[0] = next_head;
                    for (int i = 1; i < MAX_LENGTH; i++)
                        body_nxt[i] = ((LEN_W+1)'(i) < {1'b0, new_len}) ? body[i-1] : '0;
                    len_nxt     = new_len;
                    pending_nxt = (new_len == LEN_W'(MAX_LENGTH)) ? 4'd0 : pending_step;
                end
            end else if (grow && not_full) begin
                pending_nxt = (pending == 4'd15) ? 4'd15 : pending + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            body      <= start_body();
            length    <= LEN_W'(START_LEN);
            heading   <= DIR_RIGHT;
            pending   <= '0;
            dead_wall <= 1'b0;
            dead_self <= 1'b0;
        end else begin
            state     <= state_nxt;
            body      <= body_nxt;
            length    <= len_nxt;
            heading   <= heading_nxt;
            pending   <= pending_nxt;
            dead_wall <= dead_wall_nxt;
            dead_self <= dead_self_nxt;
        end
    end

    assign head  = body[0];
    assign alive = (state == RUN);
    assign full  = (length == LEN_W'(MAX_LENGTH));
endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: directed scenarios plus a random phase, all
// checked against a queue-based reference model of the snake.
module tb_snake_body_engine;
    localparam int ML = 50;
    localparam int W  = 16;
    localparam int H  = 12;

    logic clk = 1'b0;
    logic rst, sync, step, wrap_en, grow;
    logic [1:0] dir;
    logic [ML-1:0][7:0] body;
    logic [7:0] head, next_head;
    logic [5:0] length;
    logic alive, dead_wall, dead_self, full;

    logic s_sync, s_step, s_grow;
    logic [1:0] s_dir;
    logic [3:0][7:0] s_body;
    logic [7:0] s_head, s_next;
    logic [2:0] s_length;
    logic s_alive, s_dw, s_ds, s_full;

    snake_body_engine u_dut (
        .clk(clk), .rst(rst), .sync(sync), .step(step), .dir(dir), .wrap_en(wrap_en),
        .grow(grow), .body(body), .head(head), .next_head(next_head), .length(length),
        .alive(alive), .dead_wall(dead_wall), .dead_self(dead_self), .full(full));

    snake_body_engine #(.MAX_LENGTH(4)) u_small (
        .clk(clk), .rst(rst), .sync(s_sync), .step(s_step), .dir(s_dir), .wrap_en(1'b1),
        .grow(s_grow), .body(s_body), .head(s_head), .next_head(s_next), .length(s_length),
        .alive(s_alive), .dead_wall(s_dw), .dead_self(s_ds), .full(s_full));

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: segment queues, heading as a unit vector.
    int qx[$], qy[$];
    int hdx, hdy, pend;
    bit m_alive, m_dw, m_ds;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dir_vec(input logic [1:0] d, output int dx, output int dy);
        case (d)
            2'b00:   begin dx =  1; dy =  0; end
            2'b01:   begin dx = -1; dy =  0; end
            2'b10:   begin dx =  0; dy = -1; end
            default: begin dx =  0; dy =  1; end
        endcase
    endtask

    task automatic model_reset();
        qx.delete(); qy.delete();
        for (int i = 0; i < 3; i++) begin qx.push_back(4 - i); qy.push_back(5); end
        hdx = 1; hdy = 0; pend = 0;
        m_alive = 1; m_dw = 0; m_ds = 0;
    endtask

    task automatic model_target(input logic [1:0] d, output int nx, output int ny,
                                output int edx, output int edy, output bit off);
        int dx, dy;
        dir_vec(d, dx, dy);
        if (qx.size() >= 2 && dx == -hdx && dy == -hdy) begin dx = hdx; dy = hdy; end
        edx = dx; edy = dy;
        nx = qx[0] + dx; ny = qy[0] + dy;
        off = (nx < 0) || (nx >= W) || (ny < 0) || (ny >= H);
        nx = (nx + W) % W; ny = (ny + H) % H;
    endtask

    task automatic model_clock();
        int nx, ny, edx, edy, gn, nl;
        bit off, coll;
        if (sync) model_reset();
        else if (m_alive) begin
            if (step) begin
                model_target(dir, nx, ny, edx, edy, off);
                gn = ((pend + int'(grow)) > 0 && qx.size() < ML) ? 1 : 0;
                nl = qx.size() + gn;
                coll = 0;
                for (int j = 0; j < nl - 1; j++)
                    if (qx[j] == nx && qy[j] == ny) coll = 1;
                hdx = edx; hdy = edy;
                if (off && !wrap_en) begin m_alive = 0; m_dw = 1; end
                else if (coll) begin m_alive = 0; m_ds = 1; end
                else begin
                    qx.push_front(nx); qy.push_front(ny);
                    if (gn == 0) begin void'(qx.pop_back()); void'(qy.pop_back()); end
                    pend = pend + int'(grow) - gn;
                    if (pend > 15) pend = 15;
                    if (qx.size() == ML) pend = 0;
                end
            end else if (grow && qx.size() < ML) begin
                pend = (pend < 15) ? pend + 1 : 15;
            end
        end
    endtask

    function automatic logic [ML-1:0][7:0] exp_body();
        logic [ML-1:0][7:0] b = '0;
        for (int i = 0; i < qx.size(); i++) b[i] = {4'(qx[i]), 4'(qy[i])};
        return b;
    endfunction

    task automatic check_all();
        chk("body", body, exp_body());
        chk("head", head, exp_body() & 400'hFF);
        chk("length", length, qx.size());
        chk("alive", alive, m_alive);
        chk("dead_wall", dead_wall, m_dw);
        chk("dead_self", dead_self, m_ds);
        chk("full", full, qx.size() == ML);
    endtask

    // One clock: inputs applied away from the edge, next_head checked before it,
    // registered state checked just after it.
    task automatic cyc(input bit st, input logic [1:0] d, input bit gr);
        int nx, ny, edx, edy;
        bit off;
        step = st; dir = d; grow = gr;
        #1;
        model_target(dir, nx, ny, edx, edy, off);
        if (!(off && !wrap_en)) chk("next_head", next_head, {4'(nx), 4'(ny)});
        @(posedge clk);
        model_clock();
        #1;
        step = 0; grow = 0; sync = 0;
        check_all();
    endtask

    task automatic do_sync();
        sync = 1;
        cyc(0, 2'b00, 0);
    endtask

    initial begin
        rst = 1; sync = 0; step = 0; grow = 0; dir = 0; wrap_en = 1;
        s_sync = 0; s_step = 0; s_grow = 0; s_dir = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        @(negedge clk) rst = 0;
        #1;
        chk("rst_head", head, 8'h45);
        chk("rst_b1", body[1], 8'h35);
        chk("rst_b2", body[2], 8'h25);
        chk("rst_len", length, 3);

        // basic move and reversal rejection
        cyc(1, 2'b00, 0);
        chk("move_head", head, 8'h55);
        chk("move_b3", body[3], 8'h00);
        cyc(1, 2'b01, 0);
        chk("rev_head", head, 8'h65);
        cyc(1, 2'b10, 0);
        chk("up_head", head, 8'h64);

        // growth queue
        cyc(0, 2'b10, 1);
        cyc(0, 2'b10, 1);
        cyc(1, 2'b10, 0); chk("grow_len1", length, 4);
        cyc(1, 2'b10, 0); chk("grow_len2", length, 5);
        cyc(1, 2'b10, 0); chk("grow_len3", length, 5);
        cyc(1, 2'b10, 1); chk("grow_len4", length, 6);
        chk("grow_head", head, 8'h60);

        // wall death, then dead state ignores steps, sync restores
        wrap_en = 0;
        cyc(1, 2'b10, 0);
        chk("wall_alive", alive, 1'b0);
        chk("wall_flag", dead_wall, 1'b1);
        chk("wall_head", head, 8'h60);
        cyc(1, 2'b00, 1);
        cyc(1, 2'b11, 0);
        do_sync();
        chk("sync_head", head, 8'h45);
        chk("sync_alive", alive, 1'b1);

        // wrap in both axes
        wrap_en = 1;
        repeat (6) cyc(1, 2'b10, 0);
        chk("wrap_y", head, 8'h4B);
        repeat (12) cyc(1, 2'b00, 0);
        chk("wrap_x", head, 8'h0B);

        // self collision at length 5
        do_sync();
        cyc(0, 2'b00, 1);
        cyc(0, 2'b00, 1);
        cyc(1, 2'b00, 0);
        cyc(1, 2'b00, 0);
        chk("self_len", length, 5);
        cyc(1, 2'b11, 0);
        cyc(1, 2'b01, 0);
        cyc(1, 2'b10, 0);
        chk("self_flag", dead_self, 1'b1);
        chk("self_wall", dead_wall, 1'b0);

        // async reset while dead
        @(negedge clk) rst = 1;
        #1;
        model_reset();
        check_all();
        @(negedge clk) rst = 0;

        // tail-follow at length 4 is not a collision
        cyc(0, 2'b00, 1);
        cyc(1, 2'b00, 0);
        chk("tail_len", length, 4);
        cyc(1, 2'b11, 0);
        cyc(1, 2'b01, 0);
        cyc(1, 2'b10, 0);
        chk("tail_alive", alive, 1'b1);
        chk("tail_head", head, 8'h45);

        // random phase
        do_sync();
        for (int c = 0; c < 600; c++) begin
            if (c % 60 == 0) wrap_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0 || (!m_alive && $urandom_range(0, 3) == 0)) sync = 1;
            cyc($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
        end

        // full behaviour on a 4-segment instance
        @(negedge clk) s_grow = 1;
        @(negedge clk) s_grow = 1;
        @(negedge clk) s_grow = 1;
        @(negedge clk) begin s_grow = 0; s_step = 1; s_dir = 2'b00; end
        @(negedge clk);
        chk("s_len1", s_length, 4);
        chk("s_full1", s_full, 1'b1);
        @(negedge clk) s_step = 0;
        chk("s_body", s_body, 32'h35455565);
        s_grow = 1;
        @(negedge clk) begin s_grow = 0; s_step = 1; end
        @(negedge clk) s_step = 0;
        chk("s_len2", s_length, 4);
        chk("s_body2", s_body, 32'h45556575);
        chk("s_alive", s_alive, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/snake_body_engine.md
# snake_body_engine

Parametrised successor to the team's snake-body shift register. It holds the ordered segment list of one snake on an arbitrary-size grid, advances it one cell per `step` pulse, and handles queued growth, reversal rejection, wrap-or-wall edge mode, and self/wall collision with a latched death state. It sits between the direction decoder / food logic and the renderer, which reads `body`, `length` and `alive`.

## Interface
- `MAX_LENGTH`, 50: maximum segment count, ≥ 2.
- `X_BITS`, 4: x-coordinate width.
- `Y_BITS`, 4: y-coordinate width.
- `GRID_W`, 16: columns, 2..2^X_BITS.
- `GRID_H`, 12: rows, 2..2^Y_BITS.
- `START_X`, 4: reset head x. Must satisfy START_X ≥ START_LEN−1.
- `START_Y`, 5: reset head y.
- `START_LEN`, 3: reset length, 1..MAX_LENGTH.
- Segment word, `SEG_W` = X_BITS+Y_BITS: packed as {x, y}.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `sync`  in  1  synchronous soft restart to the reset state.
- `step`  in  1  single-cycle pulse; advance one cell.
- `dir`  in  2  requested direction: 00 right (x+1), 01 left (x−1), 10 up (y−1), 11 down (y+1).
- `wrap_en`  in  1  1 = edges wrap modulo grid; 0 = edges kill.
- `grow`  in  1  single-cycle pulse; queue one segment of growth.
- `body`  out  MAX_LENGTH×SEG_W  segment i at `body[i]`, where i = 0 is the head. Unused segments are 0.
- `head`  out  SEG_W  equals `body[0]`.
- `next_head`  out  SEG_W  combinational target cell for the next step.
- `length`  out  $clog2(MAX_LENGTH+1)  current segment count.
- `alive`  out  1  1 in RUN, 0 in DEAD.
- `dead_wall`  out  1  sticky; death caused by an edge.
- `dead_self`  out  1  sticky; death caused by body collision.
- `full`  out  1  length == MAX_LENGTH.

## Operation
- **States:** RUN and DEAD.
  - RUN → DEAD on a fatal step.
  - Any state → reset state on `sync`.
  - DEAD ignores `step` and `grow`.
- **Reset state** (`rst`, or `sync` at a clock edge):
  - `body[i]` = {START_X−i, START_Y} for i < START_LEN; other segments 0.
  - heading = right, `length` = START_LEN, pending = 0.
  - `alive` = 1, both dead flags = 0.
  - `full` = (START_LEN == MAX_LENGTH).
- **Heading register:** evaluated only on an accepted `step`.
  - If `length` ≥ 2 and `dir` is the exact reverse of heading, `dir` is ignored and heading is kept.
  - Otherwise heading ← `dir`.
  - The effective direction drives `next_head`, which is valid in every cycle.
- **Edge arithmetic:**
  - `wrap_en`=1: x wraps GRID_W−1 ↔ 0 and y wraps GRID_H−1 ↔ 0. Explicit compare, not bit overflow, so non-power-of-2 grids work.
  - `wrap_en`=0: a move off the grid is a wall hit.
- **Growth:**
  - pending is a 4-bit count, saturating at 15. Each `grow` adds 1.
  - A `grow` arriving in the same cycle as `step` counts for that step.
  - grow_now = (pending+grow > 0) and `length` < MAX_LENGTH.
  - new_len = `length` + grow_now.
- **Self collision:** `next_head` equals `body[j]` for any j in 0..new_len−2. The vacating tail cell is legal when not growing.
- **Accepted step, non-fatal:**
  - `body[0]` ← `next_head`.
  - `body[i]` ← `body[i−1]` for 1 ≤ i < new_len; `body[i]` ← 0 for i ≥ new_len.
  - `length` ← new_len; pending decrements if grow_now.
- **Accepted step, fatal:**
  - `body`, `length` and pending are unchanged.
  - `alive` ← 0 and the matching dead flag ← 1.
  - Wall is checked first, so only `dead_wall` is set when both apply.
- **Full:** when `length` reaches MAX_LENGTH, pending clears and further `grow` pulses are dropped.
- **Priority:** `rst` > `sync` > `step`. A `grow` without `step` only updates pending.

## Timing
- Every output except `next_head` is registered.
- A step accepted at edge N is visible on `body`, `length`, `alive` and the flags after edge N. Latency is 1 cycle.
- `step` held high for k cycles means k steps; the upstream block must pulse it.
- `rst` clears all state immediately, even mid-run or while DEAD.
- `sync` takes effect at the next edge and overrides a coincident `step`/`grow`.

## Test plan
- **Reset and basic move:** assert `rst`, release, then `step` with `dir`=00.
  - Before the step: `body[0..2]` = 0x45, 0x35, 0x25; `length`=3.
  - After the step: `body[0..3]` = 0x55, 0x45, 0x35, 0x00.
- **Reversal rejection:** with heading right, `step` with `dir`=01 → head 0x55→0x65, heading stays right. Then `dir`=10 → head 0x64.
- **Growth queue:** two `grow` pulses (length 3), then 3 steps → `length` 4, 5, 5; pending 0. A `grow` coincident with the 4th step → `length` 6.
- **Edges:**
  - `wrap_en`=0, head y=0, `dir`=10 → `alive`=0, `dead_wall`=1, `body` unchanged. Later steps do nothing; `sync` restores 0x45.
  - `wrap_en`=1: y=0 with up → y=11; x=15 with right → x=0.
- **Self collision:** length 5, head (a,b), moves down, left, up → `dead_self`=1 on the 3rd move. The same sequence at length 4 is tail-follow: no death.
- **Full:** MAX_LENGTH=4, START_LEN=3, 3 `grow` pulses, 2 steps → `length`=4, `full`=1, pending=0. Further `grow` is ignored.
